// File: rtl/pkt_seq_axil_slave.sv
// AXI4-Lite slave with four registers driving a programmable packet sequence counter.
// Writes commit one edge after both AW and W are captured; reads return the pre-update value.
module pkt_seq_axil_slave #(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  input  logic                                seq_tick,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     seq_num
);

  localparam int unsigned DataW = C_S00_AXI_DATA_WIDTH;
  localparam int unsigned StrbW = C_S00_AXI_DATA_WIDTH / 8;

  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             bvalid_q, bvalid_d;
  logic             awready_q, wready_q;
  logic [1:0]       awsel_q;
  logic [DataW-1:0] wdata_q;
  logic [StrbW-1:0] wstrb_q;
  logic             arready_q, rvalid_q, rvalid_d;
  logic [DataW-1:0] rdata_q;
  logic [DataW-1:0] ctrl_q, seq_load_q, seq_step_q, scratch_q, seq_num_q;

  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit, seq_load_hit;
  logic [DataW-1:0] wr_old, wr_merged, rd_mux;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0]};

  assign aw_hs        = s00_axi_awvalid & awready_q;
  assign w_hs         = s00_axi_wvalid & wready_q;
  assign b_hs         = bvalid_q & s00_axi_bready;
  assign ar_hs        = s00_axi_arvalid & arready_q;
  assign r_hs         = rvalid_q & s00_axi_rready;
  assign wr_commit    = aw_done_q & w_done_q;
  assign seq_load_hit = wr_commit & (awsel_q == 2'd1) & (|wstrb_q);

  always_comb begin
    wr_old = ctrl_q;
    unique case (awsel_q)
      2'd0: wr_old = ctrl_q;
      2'd1: wr_old = seq_load_q;
      2'd2: wr_old = seq_step_q;
      2'd3: wr_old = scratch_q;
    endcase
  end

  always_comb begin
    wr_merged = wr_old;
    for (int i = 0; i < StrbW; i++) begin
      if (wstrb_q[i]) wr_merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    rd_mux = ctrl_q;
    unique case (s00_axi_araddr[3:2])
      2'd0: rd_mux = ctrl_q;
      2'd1: rd_mux = seq_load_q;
      2'd2: rd_mux = seq_step_q;
      2'd3: rd_mux = scratch_q;
    endcase
  end

  // Readies are derived from next-state so they drop right after their own handshake
  // and stay low until the matching response has been accepted.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    if (aw_hs) aw_done_d = 1'b1;
    if (w_hs)  w_done_d  = 1'b1;
    if (wr_commit) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
    if (b_hs)  bvalid_d = 1'b0;
    if (ar_hs) rvalid_d = 1'b1;
    if (r_hs)  rvalid_d = 1'b0;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awsel_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bvalid_q  <= bvalid_d;
      awready_q <= ~aw_done_d & ~bvalid_d;
      wready_q  <= ~w_done_d & ~bvalid_d;
      arready_q <= ~rvalid_d;
      rvalid_q  <= rvalid_d;
      if (aw_hs) awsel_q <= s00_axi_awaddr[3:2];
      if (w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (ar_hs) rdata_q <= rd_mux;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_q     <= '0;
      seq_load_q <= '0;
      seq_step_q <= '0;
      scratch_q  <= '0;
    end else if (wr_commit) begin
      unique case (awsel_q)
        2'd0: ctrl_q     <= wr_merged;
        2'd1: seq_load_q <= wr_merged;
        2'd2: seq_step_q <= wr_merged;
        2'd3: scratch_q  <= wr_merged;
      endcase
    end
  end

  // A load takes priority over a coincident tick.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      seq_num_q <= '0;
    end else if (seq_load_hit) begin
      seq_num_q <= wr_merged;
    end else if (ctrl_q[0] && seq_tick) begin
      seq_num_q <= seq_num_q + {16'h0000, seq_step_q[15:0]};
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign seq_num         = seq_num_q;

endmodule

// File: doc/pkt_seq_axil_slave.md
PKT_SEQ_AXIL_SLAVE -- requirements
Module: pkt_seq_axil_slave

Interface
REQ-001 Parameter C_S00_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S00_AXI_ADDR_WIDTH, default 4, byte address width; 16-byte register window.
REQ-003 s00_axi_aclk  input  1  single clock for all logic.
REQ-004 s00_axi_aresetn  input  1  reset, asynchronous and active-low.
REQ-005 s00_axi_awaddr  input  4, s00_axi_awprot  input  3 (ignored), s00_axi_awvalid  input  1, s00_axi_awready  output  1: write address channel.
REQ-006 s00_axi_wdata  input  32, s00_axi_wstrb  input  4, s00_axi_wvalid  input  1, s00_axi_wready  output  1: write data channel.
REQ-007 s00_axi_bresp  output  2, s00_axi_bvalid  output  1, s00_axi_bready  input  1: write response channel.
REQ-008 s00_axi_araddr  input  4, s00_axi_arprot  input  3 (ignored), s00_axi_arvalid  input  1, s00_axi_arready  output  1: read address channel.
REQ-009 s00_axi_rdata  output  32, s00_axi_rresp  output  2, s00_axi_rvalid  output  1, s00_axi_rready  input  1: read data channel.
REQ-010 seq_tick  input  1  one-cycle advance request for the packet sequence counter.
REQ-011 seq_num  output  32  current packet sequence number.

Function
REQ-012 Register map via addr[3:2] (addr[1:0] ignored): 0 CTRL (bit0 = enable), 1 SEQ_LOAD, 2 SEQ_STEP (bits[15:0] used), 3 SCRATCH; all four fully read/write, readback returns last written value.
REQ-013 Write path: awready and wready independent; each high in idle, drops the cycle after its own handshake, captured value held.
REQ-014 AW and W accepted in either order or same cycle; register update occurs on the clock edge after both are captured.
REQ-015 Register update applies wstrb per byte lane; wstrb = 0 leaves the register unchanged but still produces a response.
REQ-016 bvalid asserts on the same edge as the register update, bresp = 2'b00 (OKAY), held stable until bready; awready/wready reassert the cycle after the B handshake.
REQ-017 No second write is accepted while a capture or B response is outstanding.
REQ-018 Read path: arready high in idle; on AR handshake, next edge sets rvalid=1 with rdata = addressed register, rresp = 2'b00; arready low until R handshake.
REQ-019 rdata/rvalid held stable until rready; arready reasserts the cycle after the R handshake.
REQ-020 Read and write paths are independent; a read sampled on the same edge as a write update returns the pre-write value.
REQ-021 A write to SEQ_LOAD (any nonzero wstrb) sets seq_num to the merged SEQ_LOAD value on the same update edge.
REQ-022 When CTRL[0]=1 and seq_tick=1, seq_num += zero-extended SEQ_STEP[15:0] per cycle, modulo 2^32 wrap.
REQ-023 SEQ_LOAD write and seq_tick on the same edge: load wins, tick dropped.
REQ-024 CTRL[0]=0: seq_tick ignored, seq_num holds.

Reset
REQ-025 While s00_axi_aresetn=0: all registers 0, seq_num 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0, awready/wready/arready 0.
REQ-026 First edge after reset release: awready, wready, arready = 1.
REQ-027 Reset mid-transaction discards captured AW/W and pending B/R; no register update completes.

Verification
REQ-028 Write 1,2,3,4 to 0x0,0x4,0x8,0xC (wstrb 0xF), read back -> rdata 1,2,3,4, all bresp/rresp OKAY.
REQ-029 W valid 3 cycles before AW, bready low 5 cycles -> single update, bvalid held 5 cycles, no ready reassert until B handshake.
REQ-030 SCRATCH=0xAABBCCDD, write 0x11223344 wstrb 0x5 -> readback 0xAA22CC44.
REQ-031 CTRL=1, SEQ_STEP=3, SEQ_LOAD=0xFFFFFFFE, 2 ticks -> seq_num 0x00000001 then 0x00000004.
REQ-032 Tick coincident with SEQ_LOAD=0x10 update, CTRL=1 -> seq_num 0x10.
REQ-033 Reset asserted with bvalid pending -> bvalid 0 immediately, registers 0, readback 0 after release.
